// File: rtl/mux_4x1_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 mux round-robin arbiter: FSM states and channel geometry.
package mux_4x1_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   localparam int N_CH = 4;
   localparam int CH_W = 2;

endpackage

// File: rtl/mux_4x1_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set bit of mask scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
   import mux_4x1_rr_arbiter_pkg::*;
(
   input  logic [N_CH-1:0] mask,
   input  logic [CH_W-1:0] ptr,
   output logic            found,
   output logic [CH_W-1:0] idx
);

   logic [CH_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int i = 0; i < N_CH; i++) begin
         // 2-bit add wraps 3 -> 0 naturally
         cand = ptr + CH_W'(i);
         if (!found && mask[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select, with a per-tenure hold limit.
module mux_4x1_rr_arbiter
   import mux_4x1_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic [N_CH-1:0] req_in,
   output logic [N_CH-1:0] grant_out,
   output logic [CH_W-1:0] sel_out,
   output logic            valid_out
);

   arb_state_e      state_q, state_d;
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [N_CH-1:0] grant_q, grant_d;
   logic [CH_W-1:0] sel_q, sel_d;
   logic            valid_q, valid_d;

   logic [N_CH-1:0] owner_bit;
   logic [N_CH-1:0] pick_mask;
   logic            pick_found;
   logic [CH_W-1:0] pick_idx;

   // While granted, the picker only ever sees the other requesters
   assign owner_bit = N_CH'(1) << sel_q;
   assign pick_mask = (state_q == ST_GRANT) ? (req_in & ~owner_bit) : req_in;

   rr_pick4 u_pick (
      .mask  (pick_mask),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      valid_d = valid_q;

      if ((state_q == ST_IDLE) || !req_in[sel_q] || (hold_q == CNT_W'(MAX_HOLD))) begin
         if (pick_found) begin
            state_d = ST_GRANT;
            ptr_d   = pick_idx + CH_W'(1);
            hold_d  = CNT_W'(1);
            grant_d = N_CH'(1) << pick_idx;
            sel_d   = pick_idx;
            valid_d = 1'b1;
         end else if (state_q == ST_GRANT && req_in[sel_q]) begin
            // Tenure expired with nobody else waiting: owner simply starts a new tenure
            hold_d = CNT_W'(1);
         end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
            grant_d = '0;
            valid_d = 1'b0;
         end
      end else begin
         hold_d = hold_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
      end
   end

   assign grant_out = grant_q;
   assign sel_out   = sel_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_mux_4x1_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk_in = 1'b0;
   logic       rst_n_in = 1'b0;
   logic [3:0] req_in = 4'b0000;
   logic [3:0] grant_out;
   logic [1:0] sel_out;
   logic       valid_out;

   int checks = 0;
   int failures = 0;

   // Behavioural model: owner = -1 when idle
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   int m_sel   = 0;

   mux_4x1_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .req_in    (req_in),
      .grant_out (grant_out),
      .sel_out   (sel_out),
      .valid_out (valid_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic int pick(input logic [3:0] m, input int p);
      for (int k = 0; k < 4; k++) begin
         if (m[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int w;
      logic [3:0] others;
      if (!rst_n_in) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
         return;
      end
      if (m_owner < 0) begin
         w = pick(req_in, m_ptr);
      end else begin
         others = req_in;
         others[m_owner] = 1'b0;
         if (req_in[m_owner] && m_hold < MAX_HOLD) begin
            m_hold++;
            return;
         end
         w = pick(others, m_ptr);
         if (w < 0 && req_in[m_owner]) begin
            m_hold = 1;
            return;
         end
      end
      if (w >= 0) begin
         m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 1;
      end else begin
         m_owner = -1; m_hold = 0;
      end
   endtask

   // Advance one clock: model sees the same req/rst the DUT samples, outputs checked 1 unit later
   task automatic tick();
      logic [3:0] exp_grant;
      model_step();
      @(posedge clk_in);
      #1;
      exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      chk("grant", grant_out, exp_grant);
      chk("valid", {3'b000, valid_out}, {3'b000, (m_owner >= 0)});
      chk("sel", {2'b00, sel_out}, 4'(m_sel));
      chk("grant_vs_sel", grant_out, valid_out ? (4'b0001 << sel_out) : 4'b0000);
   endtask

   initial begin
      // Reset held with all requests active
      rst_n_in = 1'b0; req_in = 4'b1111;
      tick(); tick();
      chk("reset_grant", grant_out, 4'b0000);
      chk("reset_valid", {3'b000, valid_out}, 4'b0000);

      // Release: ch0 first, then 8-cycle tenures rotating 0,1,2,3,0
      rst_n_in = 1'b1;
      tick();
      chk("first_grant_ch0", grant_out, 4'b0001);
      repeat (7) tick();
      chk("ch0_tenure_end", grant_out, 4'b0001);
      tick();
      chk("rotate_ch1", grant_out, 4'b0010);
      repeat (24) tick();
      chk("rotate_back_ch0", grant_out, 4'b0001);

      // Release hand-off: ch1 granted, ch3 waiting, ch1 drops
      rst_n_in = 1'b0; tick();
      rst_n_in = 1'b1; req_in = 4'b0010; tick();
      chk("handoff_own_ch1", grant_out, 4'b0010);
      req_in = 4'b1010; repeat (2) tick();
      req_in = 4'b1000; tick();
      chk("handoff_ch3", grant_out, 4'b1000);
      chk("handoff_sel3", {2'b00, sel_out}, 4'd3);
      chk("handoff_valid", {3'b000, valid_out}, 4'b0001);

      // Sole requester ch2 for 20 cycles: no rotation, no valid gap
      req_in = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("sole_ch2", grant_out, 4'b0100);
      end

      // Wrap-around: ptr sits at 3 after ch2, ch0 must beat ch1
      req_in = 4'b0011; tick();
      chk("wrap_ch0", grant_out, 4'b0001);
      req_in = 4'b0010; tick();
      chk("wrap_then_ch1", grant_out, 4'b0010);

      // Mid-tenure reset at hold 5 on ch2
      req_in = 4'b0100; repeat (5) tick();
      chk("mid_own_ch2", grant_out, 4'b0100);
      rst_n_in = 1'b0; tick();
      chk("mid_reset_grant", grant_out, 4'b0000);
      chk("mid_reset_sel", {2'b00, sel_out}, 4'd0);
      rst_n_in = 1'b1; req_in = 4'b0110; tick();
      chk("after_reset_ch1", grant_out, 4'b0010);

      // Random traffic with sticky requests so tenures run to expiry
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req_in = 4'($urandom_range(0, 15));
         rst_n_in = ($urandom_range(0, 79) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
